// File: rtl/rs_enc_symbol_framer.sv
// Repacks UART bytes MSB-first into m-bit symbols framed as KSYM-symbol blocks for the RS encoder.
// Optional idle-timeout flush is built when RS_FRAMER_TIMEOUT_EN is defined.
module rs_enc_symbol_framer #(
   parameter int m        = 6,
   parameter int KSYM     = 58,
   parameter int BLKCNT_W = 16
`ifdef RS_FRAMER_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                flush,
   input  logic                source_ena,
   output logic                source_val,
   output logic                source_sop,
   output logic                source_eop,
   output logic [m-1:0]        rsout,
   output logic                pad_active,
   output logic [BLKCNT_W-1:0] blk_cnt
);

   localparam int AW = m + 7;
   localparam int BW = $clog2(m + 8);
   localparam int SW = $clog2(KSYM);
   localparam logic [BW-1:0] M_B      = BW'(m);
   localparam logic [SW-1:0] LAST_IDX = SW'(KSYM - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PAD} state_t;

   state_t                r_state;
   logic [AW-1:0]         r_acc;
   logic [BW-1:0]         r_bcnt;
   logic [SW-1:0]         r_sidx;
   logic                  r_flush_pend;
   logic                  r_pad_last;
   logic                  r_val;
   logic                  r_sop;
   logic                  r_eop;
   logic [m-1:0]          r_sym;
   logic                  r_pad_active;
   logic [BLKCNT_W-1:0]   r_blk_cnt;

   logic                  w_in_ready;
   logic                  w_accept;
   logic [AW-1:0]         w_acc_in;
   logic [BW-1:0]         w_bcnt_in;
   logic [m-1:0]          w_sym_data;
   logic [m-1:0]          w_sym_res;
   logic                  w_xfer;
   logic                  w_load_ok;
   logic                  w_load;
   logic [m-1:0]          w_sym;
   logic [BW-1:0]         w_bcnt_out;
   logic [SW-1:0]         w_sidx_next;
   logic                  w_partial;
   logic                  w_flush_req;

   assign w_in_ready = !reset && (r_state == ST_DATA) && (r_bcnt < M_B);
   assign w_accept   = in_valid && w_in_ready;
   assign w_xfer     = r_val && source_ena;
   assign w_load_ok  = !r_val || source_ena;

   // Accumulator holds its valid bits right-aligned; a new byte shifts in below them.
   assign w_acc_in   = w_accept ? ((r_acc << 8) | {{(AW-8){1'b0}}, in_data}) : r_acc;
   assign w_bcnt_in  = r_bcnt + (w_accept ? BW'(8) : BW'(0));
   assign w_sym_data = m'(w_acc_in >> (w_bcnt_in - M_B));
   assign w_sym_res  = m'(w_acc_in << (M_B - w_bcnt_in));

   always_comb begin
      w_load     = 1'b0;
      w_sym      = '0;
      w_bcnt_out = w_bcnt_in;
      if (r_state == ST_DATA) begin
         if (w_load_ok && (w_bcnt_in >= M_B)) begin
            w_load     = 1'b1;
            w_sym      = w_sym_data;
            w_bcnt_out = w_bcnt_in - M_B;
         end
      end else if ((r_state == ST_PAD) && !r_pad_last && w_load_ok) begin
         w_load = 1'b1;
         if (w_bcnt_in >= M_B) begin
            w_sym      = w_sym_data;
            w_bcnt_out = w_bcnt_in - M_B;
         end else if (w_bcnt_in != '0) begin
            w_sym      = w_sym_res;
            w_bcnt_out = '0;
         end
      end
   end

   // r_sidx is the block position of the next symbol to be loaded.
   assign w_sidx_next = !w_load ? r_sidx :
                        (r_sidx == LAST_IDX) ? '0 : r_sidx + SW'(1);
   assign w_partial   = (w_sidx_next != '0) || (w_bcnt_out != '0);

`ifdef RS_FRAMER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] r_idle_cnt;
   logic          w_open;
   logic          w_to_flush;

   assign w_open     = (r_state == ST_DATA) && ((r_sidx != '0) || (r_bcnt != '0));
   assign w_to_flush = w_open && !w_accept && (r_idle_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset || w_accept || !w_open) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != TW'(TIMEOUT_CYC - 1)) begin
         r_idle_cnt <= r_idle_cnt + TW'(1);
      end
   end

   assign w_flush_req = flush || w_to_flush;
`else
   assign w_flush_req = flush;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_acc        <= '0;
         r_bcnt       <= '0;
         r_sidx       <= '0;
         r_flush_pend <= 1'b0;
         r_pad_last   <= 1'b0;
         r_val        <= 1'b0;
         r_sop        <= 1'b0;
         r_eop        <= 1'b0;
         r_sym        <= '0;
         r_pad_active <= 1'b0;
         r_blk_cnt    <= '0;
      end else begin
         r_acc  <= w_acc_in;
         r_bcnt <= w_bcnt_out;
         r_sidx <= w_sidx_next;

         if (w_load) begin
            r_val <= 1'b1;
            r_sym <= w_sym;
            r_sop <= (r_sidx == '0);
            r_eop <= (r_sidx == LAST_IDX);
         end else if (w_xfer) begin
            r_val <= 1'b0;
            r_sop <= 1'b0;
            r_eop <= 1'b0;
         end

         if (w_xfer && r_eop) begin
            r_blk_cnt <= r_blk_cnt + BLKCNT_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               r_state      <= ST_DATA;
               r_flush_pend <= 1'b0;
            end
            ST_DATA: begin
               r_flush_pend <= w_flush_req;
               if (r_flush_pend && w_partial) begin
                  r_state <= ST_PAD;
               end
            end
            ST_PAD: begin
               r_flush_pend <= 1'b0;
               if (r_pad_last && w_xfer) begin
                  r_state      <= ST_DATA;
                  r_pad_last   <= 1'b0;
                  r_pad_active <= 1'b0;
               end else if (w_load) begin
                  r_pad_active <= 1'b1;
                  // Only stop once every buffered bit has landed inside a closed block.
                  if ((r_sidx == LAST_IDX) && (w_bcnt_out == '0)) begin
                     r_pad_last <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = w_in_ready;
   assign source_val = r_val;
   assign source_sop = r_sop;
   assign source_eop = r_eop;
   assign rsout      = r_sym;
   assign pad_active = r_pad_active;
   assign blk_cnt    = r_blk_cnt;

endmodule
